// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - simulation run controller: DUT reset sequencing, end detection and drain
module sim_ctrl #(
  parameter int          NUM_CH       = 8,
  parameter int          RST_CYCLES   = 2,
  parameter int          DRAIN_CYCLES = 5,
  parameter int unsigned TIMEOUT      = 32'h7FFF_FFFF,
  parameter int          HALT_ALL     = 0,
  parameter int          WATCHDOG     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] halt,
  input  logic              commit,
  input  logic              mon_error,
  input  logic              mem_error,
  output logic              dut_rst,
  output logic              finish,
  output logic              done,
  output logic [1:0]        finish_code,
  output logic [63:0]       cycle_count
);

  localparam logic [7:0]  HOLD_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);
  localparam logic [31:0] TMO_INIT   = 32'(TIMEOUT);

  localparam logic [1:0] CODE_HALT    = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_ERROR   = 2'd3;

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [7:0]          hold_cnt, hold_cnt_nxt;
  logic [7:0]          drain_cnt, drain_cnt_nxt;
  logic [31:0]         tmo_cnt, tmo_cnt_nxt;
  logic [NUM_CH-1:0]   halt_lat, halt_lat_nxt;
  logic [1:0]          finish_code_nxt;
  logic [63:0]         cycle_count_nxt;
  logic                finish_nxt;
  logic [NUM_CH-1:0]   halt_seen;
  logic                halt_cond;
  logic                err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      hold_cnt    <= 8'd0;
      drain_cnt   <= 8'd0;
      tmo_cnt     <= TMO_INIT;
      halt_lat    <= '0;
      finish_code <= 2'd0;
      cycle_count <= 64'd0;
      finish      <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      drain_cnt   <= drain_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      halt_lat    <= halt_lat_nxt;
      finish_code <= finish_code_nxt;
      cycle_count <= cycle_count_nxt;
      finish      <= finish_nxt;
    end
  end

  // Current-cycle halt bits count toward the all-halted test alongside the latches.
  assign halt_seen = halt_lat | halt;
  assign halt_cond = (HALT_ALL != 0) ? (&halt_seen) : (|halt);
  assign err       = mon_error | mem_error;

  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    drain_cnt_nxt   = drain_cnt;
    tmo_cnt_nxt     = tmo_cnt;
    halt_lat_nxt    = halt_lat;
    finish_code_nxt = finish_code;
    cycle_count_nxt = cycle_count;

    case (state)
      HOLD: begin
        hold_cnt_nxt = hold_cnt + 8'd1;
        if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        halt_lat_nxt = halt_seen;
        tmo_cnt_nxt  = ((WATCHDOG != 0) && commit) ? TMO_INIT : tmo_cnt - 32'd1;
        // The cycle that ends RUN is not counted, so cycle_count equals the event's RUN index.
        if (err) begin
          finish_code_nxt = CODE_ERROR;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_INIT;
          end
        end else if (halt_cond) begin
          finish_code_nxt = CODE_HALT;
          state_nxt       = DONE;
        end else if (tmo_cnt == 32'd0) begin
          finish_code_nxt = CODE_TIMEOUT;
          state_nxt       = DONE;
        end else begin
          cycle_count_nxt = cycle_count + 64'd1;
        end
      end
      DRAIN: begin
        drain_cnt_nxt = drain_cnt - 8'd1;
        if (drain_cnt <= 8'd1) state_nxt = DONE;
      end
      DONE: begin
      end
      default: state_nxt = HOLD;
    endcase

    finish_nxt = (state_nxt == DONE) && (state != DONE);
  end

  assign dut_rst = (state == HOLD);
  assign done    = (state == DONE);

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of monitored halt channels (1..32).
REQ-002 SHALL have parameter RST_CYCLES, default 2, cycles dut_rst is held after rst release (1..255).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 5, cycles between error detection and finish (0..255).
REQ-004 SHALL have parameter TIMEOUT, default 32'h7FFF_FFFF, cycles of RUN allowed before timeout (>=1).
REQ-005 SHALL have parameter HALT_ALL, default 0, 0 = finish on any channel halt, 1 = finish when all channels have halted.
REQ-006 SHALL have parameter WATCHDOG, default 0, 1 = timeout counter reloads on every commit.
REQ-007 SHALL have ports: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have ports: halt  input  NUM_CH  per-channel halt; commit  input  1  retirement/progress strobe.
REQ-009 SHALL have ports: mon_error  input  1  monitor error; mem_error  input  1  memory-model error.
REQ-010 SHALL have ports: dut_rst  output  1  reset to DUT; finish  output  1  one-cycle end pulse; done  output  1  sticky end flag.
REQ-011 SHALL have ports: finish_code  output  2  0 none, 1 halt, 2 timeout, 3 error; cycle_count  output  64  cycles spent in RUN.

Function
REQ-012 SHALL implement states HOLD, RUN, DRAIN, DONE; all inputs sampled on rising clk.
REQ-013 HOLD: dut_rst=1; hold counter increments; after RST_CYCLES cycles in HOLD, next state RUN and dut_rst=0 from that edge.
REQ-014 HOLD SHALL ignore halt, commit, mon_error, mem_error.
REQ-015 RUN: cycle_count increments by 1 per cycle, wraps at 2^64; timeout counter decrements by 1 per cycle from TIMEOUT.
REQ-016 WATCHDOG=1: commit=1 in a RUN cycle reloads timeout counter to TIMEOUT instead of decrementing; WATCHDOG=0 ignores commit.
REQ-017 RUN event priority per cycle: error (mon_error|mem_error) > halt condition > timeout reaching 0.
REQ-018 Error in RUN: next state DRAIN, finish_code=3, drain counter loaded with DRAIN_CYCLES; DRAIN_CYCLES=0 goes directly to DONE.
REQ-019 DRAIN: counter decrements per cycle; at 0 next state DONE; further errors, halts, timeout ignored; finish_code unchanged.
REQ-020 HALT_ALL=0: halt condition = OR of halt bits in current cycle.
REQ-021 HALT_ALL=1: sticky per-channel latch set by halt[i]; halt condition = all latched bits OR current halt bits equal all-ones; latches cleared only by rst.
REQ-022 Halt condition in RUN: next state DONE, finish_code=1.
REQ-023 Timeout: when timeout counter is 0 in a RUN cycle with no error/halt, next state DONE, finish_code=2.
REQ-024 finish SHALL be 1 for exactly the first cycle in DONE; done SHALL be 1 for every cycle in DONE.
REQ-025 DONE SHALL be terminal until rst; dut_rst stays 0, cycle_count frozen, finish_code frozen.
REQ-026 cycle_count SHALL be frozen in DRAIN and DONE.

Reset
REQ-027 rst=1 SHALL asynchronously force: state HOLD, dut_rst=1, finish=0, done=0, finish_code=0, cycle_count=0, hold/drain counters 0, timeout counter TIMEOUT, halt latches 0.
REQ-028 rst asserted in any state, including mid-DRAIN or DONE, SHALL abort and restart the full sequence.

Verification
REQ-029 Default params, rst 3 cycles then low -> dut_rst=1 for exactly 2 clk edges after release, then 0; finish_code=0.
REQ-030 HALT_ALL=0, halt=8'b0000_0100 at RUN cycle 10 -> finish pulse next cycle, finish_code=1, cycle_count=10, done stays 1.
REQ-031 HALT_ALL=1, NUM_CH=4, halt bits 0,1,2 pulsed singly, bit 3 at cycle 20 -> finish only after bit 3, finish_code=1.
REQ-032 mon_error=1 at RUN cycle 7 with halt=1 same cycle -> DRAIN, finish exactly 5 cycles later, finish_code=3.
REQ-033 TIMEOUT=16, WATCHDOG=0 -> finish_code=2, cycle_count=16; WATCHDOG=1 with commit every 10 cycles -> no timeout; commit stopped -> timeout 17 cycles after last commit.
REQ-034 rst asserted during DRAIN -> immediate dut_rst=1, done=0, finish_code=0, full HOLD sequence repeats.
